wb_arbiter: RTL

Parametrised writeback arbiter between the execution units and the physical register file. It accepts results from NUM_CHANNELS functional units (ALU, FPU, LSU, BRU and any added later). Each channel has its own small FIFO. Each cycle the block drains up to NUM_PORTS entries through a rotating round-robin grant onto NUM_PORTS registered regfile write ports. It replaces the fixed one-port-per-unit writeback wiring, so any number of units can share fewer write ports without dropping results, and it adds a flush.

---
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Bundle of the producer-side result channels and the registered regfile write ports
// that surround the writeback arbiter.
interface wb_arbiter_if #(
  parameter int NUM_CHANNELS  = 4,
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int PREG_WIDTH    = 7,
  parameter int ROB_PTR_WIDTH = 6
);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0]                    wb_valid_in;
  logic [NUM_CHANNELS-1:0]                    wb_ready_out;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    wb_data_in;
  logic [NUM_CHANNELS-1:0][PREG_WIDTH-1:0]    wb_preg_in;
  logic [NUM_CHANNELS-1:0][ROB_PTR_WIDTH-1:0] wb_rob_ptr_in;

  logic [NUM_PORTS-1:0]                       wr_valid_out;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]       wr_data_out;
  logic [NUM_PORTS-1:0][PREG_WIDTH-1:0]       wr_preg_out;
  logic [NUM_PORTS-1:0][ROB_PTR_WIDTH-1:0]    wr_rob_ptr_out;
  logic [NUM_PORTS-1:0][CW-1:0]               wr_chan_out;

  modport master (
    output wb_valid_in, wb_data_in, wb_preg_in, wb_rob_ptr_in,
    input  wb_ready_out,
    input  wr_valid_out, wr_data_out, wr_preg_out, wr_rob_ptr_out, wr_chan_out
  );

  modport slave (
    input  wb_valid_in, wb_data_in, wb_preg_in, wb_rob_ptr_in,
    output wb_ready_out,
    output wr_valid_out, wr_data_out, wr_preg_out, wr_rob_ptr_out, wr_chan_out
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs drained round-robin onto NUM_PORTS
// registered regfile write ports, with synchronous flush.
module wb_arbiter #(
  parameter int NUM_CHANNELS  = 4,
  parameter int NUM_PORTS     = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int PREG_WIDTH    = 7,
  parameter int ROB_PTR_WIDTH = 6
) (
  input  logic         clk_in,
  input  logic         rst_N_in,
  input  logic         flush_in,
  wb_arbiter_if.slave  wb
);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    data;
    logic [PREG_WIDTH-1:0]    preg;
    logic [ROB_PTR_WIDTH-1:0] rob;
  } entry_t;

  entry_t                              mem_q [NUM_CHANNELS][FIFO_DEPTH];
  logic [NUM_CHANNELS-1:0][AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [NUM_CHANNELS-1:0][AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NUM_CHANNELS-1:0][NW-1:0]     count_q, count_d;
  logic [CW-1:0]                       rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]                wr_valid_q, wr_valid_d;
  entry_t [NUM_PORTS-1:0]              wr_ent_q, wr_ent_d;
  logic [NUM_PORTS-1:0][CW-1:0]        wr_chan_q, wr_chan_d;

  logic [NUM_CHANNELS-1:0]             ready, push, pop;
  logic [NUM_PORTS-1:0]                gnt_vld;
  logic [NUM_PORTS-1:0][CW-1:0]        gnt_chan;
  logic [CW-1:0]                       last_chan;
  logic [CW:0]                         scan_idx;
  logic [CW-1:0]                       scan_ch;
  logic                                placed;

  // Ready looks only at the registered count, so a same-cycle pop never opens a slot.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ready[c] = (count_q[c] < NW'(FIFO_DEPTH));
      push[c]  = wb.wb_valid_in[c] & ready[c] & ~flush_in;
    end
  end

  always_comb begin
    gnt_vld   = '0;
    gnt_chan  = '0;
    pop       = '0;
    last_chan = rr_ptr_q;
    scan_idx  = '0;
    scan_ch   = '0;
    placed    = 1'b0;
    if (!flush_in) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        scan_idx = {1'b0, rr_ptr_q} + (CW+1)'(i);
        if (scan_idx >= (CW+1)'(NUM_CHANNELS))
          scan_idx = scan_idx - (CW+1)'(NUM_CHANNELS);
        scan_ch = scan_idx[CW-1:0];
        placed  = 1'b0;
        // Each non-empty channel takes the lowest free port, so grant k lands on port k.
        if (count_q[scan_ch] != '0) begin
          for (int k = 0; k < NUM_PORTS; k++) begin
            if (!placed && !gnt_vld[k]) begin
              gnt_vld[k]    = 1'b1;
              gnt_chan[k]   = scan_ch;
              pop[scan_ch]  = 1'b1;
              last_chan     = scan_ch;
              placed        = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + AW'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + AW'(pop[c]);
      case ({push[c], pop[c]})
        2'b10:   count_d[c] = count_q[c] + 1'b1;
        2'b01:   count_d[c] = count_q[c] - 1'b1;
        default: count_d[c] = count_q[c];
      endcase
    end

    if (flush_in)
      rr_ptr_d = '0;
    else if (|gnt_vld)
      rr_ptr_d = (last_chan == CW'(NUM_CHANNELS - 1)) ? '0 : last_chan + 1'b1;
    else
      rr_ptr_d = rr_ptr_q;

    for (int k = 0; k < NUM_PORTS; k++) begin
      wr_valid_d[k] = gnt_vld[k];
      wr_ent_d[k]   = wr_ent_q[k];
      wr_chan_d[k]  = wr_chan_q[k];
      if (gnt_vld[k]) begin
        wr_ent_d[k]  = mem_q[gnt_chan[k]][rd_ptr_q[gnt_chan[k]]];
        wr_chan_d[k] = gnt_chan[k];
      end
    end

    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rr_ptr_q   <= '0;
      wr_valid_q <= '0;
      wr_ent_q   <= '0;
      wr_chan_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_ent_q   <= wr_ent_d;
      wr_chan_q  <= wr_chan_d;
    end
  end

  // FIFO storage is pure data; validity is carried entirely by the counts.
  always_ff @(posedge clk_in) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (push[c])
        mem_q[c][wr_ptr_q[c]] <= '{data: wb.wb_data_in[c],
                                   preg: wb.wb_preg_in[c],
                                   rob:  wb.wb_rob_ptr_in[c]};
    end
  end

  assign wb.wb_ready_out = ready;
  assign wb.wr_valid_out = wr_valid_q;
  assign wb.wr_chan_out  = wr_chan_q;

  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      wb.wr_data_out[k]    = wr_ent_q[k].data;
      wb.wr_preg_out[k]    = wr_ent_q[k].preg;
      wb.wr_rob_ptr_out[k] = wr_ent_q[k].rob;
    end
  end
endmodule
